// File: rtl/lzc_wire_pkg.sv
// lzc_wire: definitions shared by the leading/trailing-zero pipeline.
//   - lzc_mode_e : count direction (LZC_LEAD counts from the MSB,
//                  LZC_TRAIL counts from the LSB)
//   - lzc_s1_t   : contents of the first pipeline register
// The stage-1 struct is sized for the widest supported operand. Narrower
// instances use only the low bits, and the upper bits are always loaded as zero.
package lzc_wire;

  localparam int LZC_MAX_WIDTH = 128;
  localparam int LZC_MAX_CW    = 7;

  typedef enum logic {
    LZC_LEAD  = 1'b0,
    LZC_TRAIL = 1'b1
  } lzc_mode_e;

  typedef struct packed {
    lzc_mode_e                mode;
    logic                     nz;
    logic [LZC_MAX_CW-1:0]    cnt;
    logic [LZC_MAX_WIDTH-1:0] operand;
  } lzc_s1_t;

endpackage

// File: rtl/lzc_tree.sv
// lzc_tree: combinational leading-zero counter built as a recursive half-split.
// Ports:
//   a   in  WIDTH            operand (WIDTH a power of two, >= 2)
//   cnt out log2(WIDTH)      zeros above the most significant set bit
//   nz  out 1                operand has at least one set bit
// When nz is 0, cnt is meaningless and the caller must mask it.
module lzc_tree #(
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  output logic [CW-1:0]    cnt,
  output logic             nz
);

  generate
    if (WIDTH == 2) begin : g_leaf
      assign nz  = a[1] | a[0];
      assign cnt = ~a[1];
    end else begin : g_split
      localparam int HW = WIDTH / 2;

      logic [CW-2:0] hi_cnt;
      logic [CW-2:0] lo_cnt;
      logic          hi_nz;
      logic          lo_nz;

      lzc_tree #(.WIDTH(HW)) u_hi (
        .a   (a[WIDTH-1:HW]),
        .cnt (hi_cnt),
        .nz  (hi_nz)
      );

      lzc_tree #(.WIDTH(HW)) u_lo (
        .a   (a[HW-1:0]),
        .cnt (lo_cnt),
        .nz  (lo_nz)
      );

      // A set bit in the upper half wins. Otherwise the whole upper half
      // counts as zeros, and that sets the MSB of the count.
      assign nz  = hi_nz | lo_nz;
      assign cnt = hi_nz ? {1'b0, hi_cnt} : {1'b1, lo_cnt};
    end
  endgenerate

endmodule

// File: rtl/lzc_pipe.sv
// lzc_pipe: two-stage pipelined leading/trailing zero counter with normalise.
// Ports:
//   clock     in  1      rising-edge clock
//   reset     in  1      synchronous active-high reset
//   flush     in  1      kills every in-flight item at the next edge
//   in_valid  in  1      operand present
//   in_ready  out 1      operand accepted when in_valid & in_ready
//   in_a      in  WIDTH  operand
//   in_mode   in  1      0 = leading-zero count, 1 = trailing-zero count
//   out_valid out 1      result present
//   out_ready in  1      consumer takes the result
//   out_cnt   out CW     zero count (0 for an all-zero operand)
//   out_nz    out 1      operand had at least one set bit
//   out_norm  out WIDTH  operand shifted left (mode 0) or right (mode 1) by out_cnt
// Stage 1 registers the operand, mode and count. Stage 2 registers the count,
// nz and shifted operand.
module lzc_pipe
  import lzc_wire::*;
#(
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_cnt,
  output logic             out_nz,
  output logic [WIDTH-1:0] out_norm
);

  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] tree_in;
  logic [CW-1:0]    tree_cnt;
  logic             tree_nz;

  lzc_s1_t          s1_d;
  lzc_s1_t          s1_q;
  logic             s1_valid;
  logic             s2_valid;

  logic [WIDTH-1:0] s1_op;
  logic [CW-1:0]    s1_cnt;
  logic             s1_trail;
  logic [WIDTH-1:0] op_rev;
  logic [WIDTH-1:0] shift_src;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shl_rev;
  logic [WIDTH-1:0] norm_d;

  logic [CW-1:0]    cnt_q;
  logic             nz_q;
  logic [WIDTH-1:0] norm_q;

  logic             s2_free;
  logic             accept;
  logic             s1_move;

  // Trailing mode reuses the leading-zero tree and the left shifter by
  // bit-reversing on the way in and on the way out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign a_rev[i]   = in_a[WIDTH-1-i];
    assign op_rev[i]  = s1_op[WIDTH-1-i];
    assign shl_rev[i] = shl[WIDTH-1-i];
  end

  assign tree_in = in_mode ? a_rev : in_a;

  lzc_tree #(.WIDTH(WIDTH)) u_tree (
    .a   (tree_in),
    .cnt (tree_cnt),
    .nz  (tree_nz)
  );

  // Stage-1 payload. The count is forced to zero for an all-zero operand.
  always_comb begin
    s1_d         = '0;
    s1_d.mode    = lzc_mode_e'(in_mode);
    s1_d.nz      = tree_nz;
    s1_d.cnt     = LZC_MAX_CW'(tree_nz ? tree_cnt : '0);
    s1_d.operand = LZC_MAX_WIDTH'(in_a);
  end

  assign s1_op     = s1_q.operand[WIDTH-1:0];
  assign s1_cnt    = s1_q.cnt[CW-1:0];
  assign s1_trail  = (s1_q.mode == LZC_TRAIL);
  assign shift_src = s1_trail ? op_rev : s1_op;
  assign shl       = shift_src << s1_cnt;
  assign norm_d    = s1_trail ? shl_rev : shl;

  // Narrow instances leave the padding of the stage-1 struct unused.
  if (WIDTH < LZC_MAX_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{s1_q.operand[LZC_MAX_WIDTH-1:WIDTH],
                          s1_q.cnt[LZC_MAX_CW-1:CW]};
  end

  // Stage 2 can load when it is empty or its result is being taken.
  // Stage 1 can load when it is empty or its item moves on.
  assign s2_free  = ~s2_valid | out_ready;
  assign in_ready = ~s1_valid | s2_free;
  assign accept   = in_valid & in_ready;
  assign s1_move  = s1_valid & s2_free;

  // Valid bits. Flush clears both and overrides a same-cycle accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_free)  s2_valid <= s1_valid;
    end
  end

  // Data registers change only when their stage advances, so the outputs
  // stay put while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      cnt_q  <= '0;
      nz_q   <= 1'b0;
      norm_q <= '0;
    end else begin
      if (accept && !flush) begin
        s1_q <= s1_d;
      end
      if (s1_move && !flush) begin
        cnt_q  <= s1_cnt;
        nz_q   <= s1_q.nz;
        norm_q <= norm_d;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_cnt   = cnt_q;
  assign out_nz    = nz_q;
  assign out_norm  = norm_q;

endmodule

// File: tb/tb_lzc_pipe.sv
// tb_lzc_pipe: directed bench for lzc_pipe at WIDTH=64.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, or 1 ns after it when a same-cycle handshake has to be observed.
module tb_lzc_pipe;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_cnt;
  logic        out_nz;
  logic [63:0] out_norm;

  int checks = 0;
  int errors = 0;

  localparam int NDIR = 11;
  localparam logic [63:0] DIR_A [NDIR] = '{
    64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000,
    64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000,
    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
    64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000,
    64'h0000_0000_0000_0001, 64'h00F0_0000_0000_0000,
    64'h00F0_0000_0000_0000
  };
  localparam logic DIR_M [NDIR] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  localparam logic [5:0] DIR_CNT [NDIR] = '{48, 15, 0, 0, 0, 0, 31, 63, 63, 52, 8};
  localparam logic DIR_NZ [NDIR] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  localparam logic [63:0] DIR_NORM [NDIR] = '{
    64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,
    64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000,
    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
    64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,
    64'h8000_0000_0000_0000, 64'h0000_0000_0000_000F,
    64'hF000_0000_0000_0000
  };

  lzc_pipe #(.WIDTH(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_nz    (out_nz),
    .out_norm  (out_norm)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model packed as {nz, cnt, norm}. It works by scanning the bits.
  function automatic logic [70:0] model(input logic [63:0] a, input logic m);
    int   c;
    logic found;
    logic [63:0] n;
    c = 0;
    found = 1'b0;
    if (a == 64'd0) return '0;
    if (!m) begin
      for (int i = 63; i >= 0; i--) begin
        if (!found && a[i]) begin c = 63 - i; found = 1'b1; end
      end
      n = a << c;
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (!found && a[i]) begin c = i; found = 1'b1; end
      end
      n = a >> c;
    end
    return {1'b1, 6'(c), n};
  endfunction

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_cnt !== 6'd0) begin errors++; $display("[TB] FAIL reset_out_cnt: got %0d want 0", out_cnt); end
    checks++;
    if (out_nz !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_nz: got %b want 0", out_nz); end
    checks++;
    if (out_norm !== 64'd0) begin errors++; $display("[TB] FAIL reset_out_norm: got %h want 0", out_norm); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    out_ready = 1'b1;
    for (int k = 0; k < NDIR; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_a     = DIR_A[k];
      in_mode  = DIR_M[k];
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_early_valid: got %b want 0", k, out_valid); end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_valid: got %b want 1", k, out_valid); end
      checks++;
      if (out_cnt !== DIR_CNT[k]) begin errors++; $display("[TB] FAIL dir%0d_cnt: got %0d want %0d", k, out_cnt, DIR_CNT[k]); end
      checks++;
      if (out_nz !== DIR_NZ[k]) begin errors++; $display("[TB] FAIL dir%0d_nz: got %b want %b", k, out_nz, DIR_NZ[k]); end
      checks++;
      if (out_norm !== DIR_NORM[k]) begin errors++; $display("[TB] FAIL dir%0d_norm: got %h want %h", k, out_norm, DIR_NORM[k]); end
    end
  endtask

  task automatic test_stream;
    logic [70:0] exp_q [$];
    logic [70:0] exp_v;
    logic [70:0] held_val;
    logic        held;
    int sent;
    int recvd;
    int cyc;
    sent = 0;
    recvd = 0;
    cyc = 0;
    held = 1'b0;
    held_val = '0;
    while (recvd < 64 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || {out_nz, out_cnt, out_norm} !== held_val) begin
          errors++;
          $display("[TB] FAIL stream_stall_hold: got v=%b %h want v=1 %h", out_valid, {out_nz, out_cnt, out_norm}, held_val);
        end
      end
      in_valid  = (sent < 64);
      in_a      = (sent < 64) ? (64'd1 << sent) : 64'd0;
      in_mode   = sent[0];
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_extra: got %h want no result", {out_nz, out_cnt, out_norm});
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_nz, out_cnt, out_norm} !== exp_v) begin
            errors++;
            $display("[TB] FAIL stream_item%0d: got %h want %h", recvd, {out_nz, out_cnt, out_norm}, exp_v);
          end
        end
        recvd++;
      end
      held     = out_valid && !out_ready;
      held_val = {out_nz, out_cnt, out_norm};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_mode));
        sent++;
      end
    end
    checks++;
    if (recvd != 64) begin errors++; $display("[TB] FAIL stream_timeout: got %0d results want 64", recvd); end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_flush;
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 64'h0000_0000_0000_8000;
    in_mode   = 1'b0;
    @(negedge clock);
    in_a    = 64'h0000_0000_0000_00FF;
    in_mode = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_fill_valid: got %b want 1", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_fill_ready: got %b want 0", in_ready); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_a     = 64'h0000_0000_0000_0001;
    in_mode  = 1'b0;
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b want 1", in_ready); end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_dominates_accept: got %b want 0", out_valid); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 64'h0000_0000_0000_8000;
    in_mode   = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_after_early: got %b want 0", out_valid); end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_after_valid: got %b want 1", out_valid); end
    checks++;
    if (out_cnt !== 6'd15) begin errors++; $display("[TB] FAIL flush_after_cnt: got %0d want 15", out_cnt); end
    checks++;
    if (out_norm !== 64'd1) begin errors++; $display("[TB] FAIL flush_after_norm: got %h want 1", out_norm); end
  endtask

  task automatic test_reset_midflight;
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 64'h0000_0000_0000_0001;
    in_mode   = 1'b0;
    @(negedge clock);
    in_a    = 64'h0000_0000_0000_0002;
    in_mode = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b want 1", in_ready); end
    checks++;
    if ({out_nz, out_cnt, out_norm} !== 71'd0) begin errors++; $display("[TB] FAIL midrst_data: got %h want 0", {out_nz, out_cnt, out_norm}); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 64'h0000_0100_0000_0000;
    in_mode   = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale_item: got %b want 0", out_valid); end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_new_valid: got %b want 1", out_valid); end
    checks++;
    if (out_cnt !== 6'd23 || out_nz !== 1'b1) begin errors++; $display("[TB] FAIL midrst_new_cnt: got %0d/%b want 23/1", out_cnt, out_nz); end
    checks++;
    if (out_norm !== 64'h8000_0000_0000_0000) begin errors++; $display("[TB] FAIL midrst_new_norm: got %h want 8000000000000000", out_norm); end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_trailing: got %b want 0", out_valid); end
  endtask

  // Scenario sequence. The bench starts in reset with all inputs idle.
  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 64'd0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    test_reset;
    test_directed;
    test_stream;
    test_flush;
    test_reset_midflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzc_pipe.md
LZC_PIPE -- requirements
Module: lzc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width; power of two, 8..128.
REQ-002 SHALL have localparam CW = log2(WIDTH), default 6, count width.
REQ-003 SHALL have port clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  synchronous kill of all in-flight items.
REQ-006 SHALL have port in_valid  in  1  operand present.
REQ-007 SHALL have port in_ready  out  1  operand accepted when in_valid & in_ready.
REQ-008 SHALL have port in_a  in  WIDTH  operand.
REQ-009 SHALL have port in_mode  in  1  0 = leading-zero count, 1 = trailing-zero count.
REQ-010 SHALL have port out_valid  out  1  result present.
REQ-011 SHALL have port out_ready  in  1  consumer accepts result.
REQ-012 SHALL have port out_cnt  out  CW  zero count.
REQ-013 SHALL have port out_nz  out  1  operand had at least one set bit.
REQ-014 SHALL have port out_norm  out  WIDTH  in_a shifted left by out_cnt in mode 0, right by out_cnt in mode 1.

Function
REQ-015 Mode 0: out_cnt SHALL equal the number of zeros above the most significant set bit; mode 1: the number of zeros below the least significant set bit.
REQ-016 All-zero operand: out_nz=0, out_cnt=0, out_norm=0, in either mode.
REQ-017 Pipeline SHALL have two register stages: S1 holds operand, mode and count; S2 holds count, nz and shifted operand.
REQ-018 Latency SHALL be exactly 2 cycles from the accept edge to out_valid when out_ready stays high.
REQ-019 Throughput SHALL be one operand per cycle when out_ready is held high.
REQ-020 Stage k SHALL advance when its successor is empty or is advancing; in_ready = ~S1_valid | S1 advancing, combinational.
REQ-021 out_* SHALL hold stable while out_valid & ~out_ready; no item lost or duplicated under arbitrary backpressure.
REQ-022 Simultaneous accept into S1 and transfer S1->S2 in one cycle SHALL be supported.
REQ-023 flush SHALL clear both valid bits at the next edge and dominate same-cycle acceptance; in_ready is don't-care during flush.
REQ-024 Mode SHALL travel with its operand; mixed-mode back-to-back streams SHALL be correct.
REQ-025 Data registers SHALL load only on advance; data content with valid low is unspecified.

Reset
REQ-026 reset high at an edge SHALL clear S1_valid and S2_valid; out_valid=0 the following cycle.
REQ-027 After reset: out_cnt=0, out_nz=0, out_norm=0; data registers are reset too.
REQ-028 Reset asserted mid-operation SHALL discard in-flight items; no result from before reset appears after it.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Mode encodings (LZC_LEAD=0, LZC_TRAIL=1) SHALL live in shared package lzc_wire, along with a struct typedef for the stage-1 register.
REQ-031 Counting SHALL be one combinational sub-module, lzc_tree, parametrised by WIDTH, built as a recursive half-split; the upper half's valid selects the half and forms the MSB of the count.
REQ-032 Trailing mode SHALL bit-reverse the operand before lzc_tree; the right shift SHALL be done by reversing, left-shifting and reversing back.

Verification (WIDTH=64)
REQ-033 in_a=0x0000_0000_0000_8000, mode 0, out_ready=1 -> after 2 cycles out_cnt=48, out_nz=1, out_norm=0x8000_0000_0000_0000.
REQ-034 in_a=0x0000_0000_0000_8000, mode 1 -> out_cnt=15, out_norm=0x0000_0000_0000_0001.
REQ-035 in_a=0 in both modes -> out_nz=0, out_cnt=0, out_norm=0; in_a=0xFFFF_FFFF_FFFF_FFFF -> out_cnt=0, out_nz=1.
REQ-036 Stream 1<<0..1<<63, alternating modes, random out_ready 50% -> every result in order, bit-exact against a scoreboard, outputs stable while stalled.
REQ-037 Fill both stages with out_ready=0, then assert flush -> out_valid=0 next cycle, in_ready=1; the next operand completes normally.
REQ-038 Reset pulse while two items are in flight -> neither emerges; the first post-reset operand appears at cycle 2.
